// File: rtl/ahb_qos_arbiter_pkg.sv
// rtl/ahb_qos_arbiter_pkg.sv - shared AHB encodings, burst lengths and port index type
package ahb_qos_arbiter_pkg;

   localparam int NUM_PORTS = 4;

   typedef logic [1:0] port_idx_t;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   // Beats still to come after the NONSEQ beat of each burst type
   localparam logic [3:0] BEATS_LEFT_16   = 4'd14;
   localparam logic [3:0] BEATS_LEFT_8    = 4'd6;
   localparam logic [3:0] BEATS_LEFT_4    = 4'd2;
   localparam logic [3:0] BEATS_LEFT_INCR = 4'd2;

endpackage

// File: rtl/ahb_burst_tracker.sv
// rtl/ahb_burst_tracker.sv - burst beat counter, ownership hold flag and early-INCR counter
module ahb_burst_tracker
   import ahb_qos_arbiter_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       hready_i,
   input  logic       hsel_i,
   input  logic [1:0] htrans_i,
   input  logic [2:0] hburst_i,
   output logic       next_hold_o
);

   htrans_e    trans;
   hburst_e    burst;
   logic [3:0] cnt_q, cnt_d;
   logic       hold_q, hold_d;
   logic [1:0] early_q, early_d;

   assign trans       = htrans_e'(htrans_i);
   assign burst       = hburst_e'(hburst_i);
   assign next_hold_o = hold_d;

   always_comb begin
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      early_d = early_q;
      if (hready_i) begin
         if (!hsel_i || trans == HTRANS_IDLE) begin
            cnt_d  = '0;
            hold_d = 1'b0;
         end else begin
            case (trans)
               HTRANS_NONSEQ: begin
                  hold_d = 1'b1;
                  case (burst)
                     HBURST_SINGLE: begin
                        cnt_d  = '0;
                        hold_d = 1'b0;
                     end
                     // A second early-ended INCR stops locking the owner in
                     HBURST_INCR: begin
                        cnt_d  = BEATS_LEFT_INCR;
                        hold_d = (early_q != 2'd1);
                     end
                     HBURST_WRAP4, HBURST_INCR4:   cnt_d = BEATS_LEFT_4;
                     HBURST_WRAP8, HBURST_INCR8:   cnt_d = BEATS_LEFT_8;
                     HBURST_WRAP16, HBURST_INCR16: cnt_d = BEATS_LEFT_16;
                     default:                      cnt_d = '0;
                  endcase
                  if (hold_q && early_q != 2'd3) early_d = early_q + 2'd1;
               end
               HTRANS_SEQ: begin
                  if (cnt_q == 4'd0) hold_d = 1'b0;
                  else               cnt_d  = cnt_q - 4'd1;
               end
               default: ;
            endcase
         end
         if (!hold_d) early_d = '0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q   <= '0;
         hold_q  <= 1'b0;
         early_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         early_q <= early_d;
      end
   end

endmodule

// File: rtl/ahb_qos_arbiter.sv
// rtl/ahb_qos_arbiter.sv - 4-port AHB arbiter: burst/lock hold, starvation promotion, priority with round-robin ties
module ahb_qos_arbiter
   import ahb_qos_arbiter_pkg::*;
#(
   parameter int unsigned AGE_LIMIT = 15
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic [3:0] req,
   input  logic [7:0] prio_cfg,
   input  logic       HREADYM,
   input  logic       HSELM,
   input  logic [1:0] HTRANSM,
   input  logic [2:0] HBURSTM,
   input  logic       HMASTLOCKM,
   output logic [1:0] grant_port,
   output logic       no_port,
   output logic [3:0] starved
);

   localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

   port_idx_t  grant_q, grant_d, start, idx, pick;
   logic       no_port_q, no_port_d, found, next_hold, any_starved;
   logic [1:0] best, prio_val;
   logic [3:0] contenders;
   logic [3:0] age_q [NUM_PORTS];
   logic [3:0] age_d [NUM_PORTS];

   ahb_burst_tracker u_burst (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .hready_i    (HREADYM),
      .hsel_i      (HSELM),
      .htrans_i    (HTRANSM),
      .hburst_i    (HBURSTM),
      .next_hold_o (next_hold)
   );

   always_comb begin
      for (int n = 0; n < NUM_PORTS; n++) starved[n] = (age_q[n] == AGE_MAX);
   end

   // Starved requesters bypass priority: first one in round-robin order wins
   always_comb begin
      grant_d     = grant_q;
      no_port_d   = no_port_q;
      start       = no_port_q ? port_idx_t'(0) : grant_q + 2'd1;
      any_starved = |(starved & req);
      contenders  = any_starved ? (starved & req) : req;
      idx         = '0;
      pick        = start;
      found       = 1'b0;
      best        = '0;
      prio_val    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx      = start + 2'(k);
         prio_val = prio_cfg[{idx, 1'b0} +: 2];
         if (contenders[idx] && (!found || (!any_starved && prio_val > best))) begin
            found = 1'b1;
            pick  = idx;
            best  = prio_val;
         end
      end
      if (HREADYM && !HMASTLOCKM && !next_hold) begin
         if (found) begin
            grant_d   = pick;
            no_port_d = 1'b0;
         end else if (!HSELM || no_port_q) begin
            no_port_d = 1'b1;
         end
      end
   end

   always_comb begin
      for (int n = 0; n < NUM_PORTS; n++) begin
         age_d[n] = age_q[n];
         if (HREADYM) begin
            if (!req[n] || (!no_port_d && grant_d == port_idx_t'(n))) age_d[n] = '0;
            else if (age_q[n] >= AGE_MAX)                             age_d[n] = AGE_MAX;
            else                                                      age_d[n] = age_q[n] + 4'd1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         grant_q   <= '0;
         no_port_q <= 1'b1;
         for (int n = 0; n < NUM_PORTS; n++) age_q[n] <= '0;
      end else begin
         grant_q   <= grant_d;
         no_port_q <= no_port_d;
         for (int n = 0; n < NUM_PORTS; n++) age_q[n] <= age_d[n];
      end
   end

   assign grant_port = grant_q;
   assign no_port    = no_port_q;

endmodule

// File: tb/tb_ahb_qos_arbiter.sv
// tb/tb_ahb_qos_arbiter.sv - directed and randomized checks of ahb_qos_arbiter against a behavioural model
module tb_ahb_qos_arbiter;

   localparam int LIM = 15;

   logic       HCLK = 1'b0;
   logic       HRESETn = 1'b0;
   logic [3:0] req = '0;
   logic [7:0] prio_cfg = '0;
   logic       HREADYM = 1'b1;
   logic       HSELM = 1'b0;
   logic [1:0] HTRANSM = '0;
   logic [2:0] HBURSTM = '0;
   logic       HMASTLOCKM = 1'b0;
   logic [1:0] grant_port;
   logic       no_port;
   logic [3:0] starved;

   ahb_qos_arbiter #(.AGE_LIMIT(LIM)) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .req        (req),
      .prio_cfg   (prio_cfg),
      .HREADYM    (HREADYM),
      .HSELM      (HSELM),
      .HTRANSM    (HTRANSM),
      .HBURSTM    (HBURSTM),
      .HMASTLOCKM (HMASTLOCKM),
      .grant_port (grant_port),
      .no_port    (no_port),
      .starved    (starved)
   );

   initial forever #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_err = 0;

   int m_grant;
   bit m_nop;
   int m_age [4];
   int m_left;
   bit m_hold;
   int m_early;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int beats_after_nonseq(input int hb);
      case (hb)
         0:       return 0;
         1:       return 2;
         2, 3:    return 2;
         4, 5:    return 6;
         default: return 14;
      endcase
   endfunction

   task automatic model_reset();
      m_grant = 0;
      m_nop   = 1'b1;
      m_left  = 0;
      m_hold  = 1'b0;
      m_early = 0;
      for (int n = 0; n < 4; n++) m_age[n] = 0;
   endtask

   task automatic model_step();
      bit nh;
      int start, pick, best, p;
      if (HREADYM !== 1'b1) return;
      nh = m_hold;
      if (!HSELM || HTRANSM == 2'd0) begin
         m_left = 0;
         nh     = 1'b0;
      end else if (HTRANSM == 2'd2) begin
         m_left = beats_after_nonseq(int'(HBURSTM));
         nh     = (HBURSTM != 3'd0) && !(HBURSTM == 3'd1 && m_early == 1);
         if (m_hold) m_early = (m_early == 3) ? 3 : m_early + 1;
      end else if (HTRANSM == 2'd3) begin
         if (m_left == 0) nh = 1'b0;
         else             m_left = m_left - 1;
      end
      if (!nh) m_early = 0;
      m_hold = nh;
      if (!HMASTLOCKM && !nh) begin
         start = m_nop ? 0 : (m_grant + 1) % 4;
         pick  = -1;
         for (int k = 0; k < 4; k++) begin
            p = (start + k) % 4;
            if (pick < 0 && req[p] && m_age[p] == LIM) pick = p;
         end
         if (pick < 0) begin
            best = -1;
            for (int k = 0; k < 4; k++) begin
               p = (start + k) % 4;
               if (req[p] && int'(prio_cfg[2*p +: 2]) > best) begin
                  best = int'(prio_cfg[2*p +: 2]);
                  pick = p;
               end
            end
         end
         if (pick >= 0) begin
            m_grant = pick;
            m_nop   = 1'b0;
         end else if (!HSELM || m_nop) begin
            m_nop = 1'b1;
         end
      end
      for (int n = 0; n < 4; n++) begin
         if (!req[n] || (!m_nop && m_grant == n)) m_age[n] = 0;
         else if (m_age[n] < LIM)                 m_age[n] = m_age[n] + 1;
      end
   endtask

   task automatic cycle(input string tag);
      logic [3:0] exp_st;
      model_step();
      @(posedge HCLK);
      #1;
      for (int n = 0; n < 4; n++) exp_st[n] = (m_age[n] == LIM);
      check({tag, ".grant"}, 32'(grant_port), 32'(m_grant));
      check({tag, ".no_port"}, 32'(no_port), 32'(m_nop));
      check({tag, ".starved"}, 32'(starved), 32'(exp_st));
   endtask

   task automatic apply_reset();
      HRESETn = 1'b0;
      #2;
      check("rst.no_port", 32'(no_port), 32'd1);
      check("rst.grant", 32'(grant_port), 32'd0);
      check("rst.starved", 32'(starved), 32'd0);
      model_reset();
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
   endtask

   task automatic set_bus(input logic sel, input logic [1:0] tr, input logic [2:0] bu);
      HSELM   = sel;
      HTRANSM = tr;
      HBURSTM = bu;
   endtask

   initial begin
      @(posedge HCLK);
      #1;
      apply_reset();

      // single requester
      req = 4'b0100;
      cycle("s1");
      check("s1.grant2", 32'(grant_port), 32'd2);
      check("s1.owned", 32'(no_port), 32'd0);

      // INCR4 owner keeps grant against a higher-priority requester
      req = 4'b0010;
      cycle("s2.setup");
      req      = 4'b1010;
      prio_cfg = 8'b1100_0000;
      set_bus(1'b1, 2'd2, 3'd3);
      cycle("s2.nonseq");
      check("s2.beat1", 32'(grant_port), 32'd1);
      HTRANSM = 2'd3;
      cycle("s2.seq1");
      check("s2.beat2", 32'(grant_port), 32'd1);
      cycle("s2.seq2");
      check("s2.beat3", 32'(grant_port), 32'd1);
      cycle("s2.seq3");
      check("s2.move3", 32'(grant_port), 32'd3);
      set_bus(1'b0, 2'd0, 3'd0);

      // starvation promotion, with a stall in the middle
      apply_reset();
      prio_cfg = 8'b0000_0011;
      req      = 4'b0101;
      cycle("s3.first");
      check("s3.grant0", 32'(grant_port), 32'd0);
      for (int i = 0; i < 9; i++) cycle("s3.age");
      HREADYM = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req = 4'($urandom);
         cycle("s5.stall");
         check("s5.grant", 32'(grant_port), 32'd0);
         check("s5.no_port", 32'(no_port), 32'd0);
         check("s5.starved", 32'(starved), 32'd0);
      end
      HREADYM = 1'b1;
      req     = 4'b0101;
      for (int i = 0; i < 4; i++) cycle("s3.age2");
      check("s3.not_yet", 32'(starved), 32'd0);
      cycle("s3.limit");
      check("s3.starved2", 32'(starved), 32'b0100);
      check("s3.still0", 32'(grant_port), 32'd0);
      cycle("s3.promote");
      check("s3.grant2", 32'(grant_port), 32'd2);
      check("s3.cleared", 32'(starved), 32'd0);

      // locked transfer
      apply_reset();
      prio_cfg = 8'h00;
      req      = 4'b0001;
      cycle("s4.setup");
      HMASTLOCKM = 1'b1;
      req        = 4'b1110;
      set_bus(1'b1, 2'd2, 3'd0);
      for (int i = 0; i < 6; i++) begin
         cycle("s4.locked");
         check("s4.keep0", 32'(grant_port), 32'd0);
      end
      HMASTLOCKM = 1'b0;
      set_bus(1'b1, 2'd0, 3'd0);
      cycle("s4.unlock");
      check("s4.grant1", 32'(grant_port), 32'd1);

      // back-to-back early-terminated INCR bursts
      apply_reset();
      set_bus(1'b0, 2'd0, 3'd0);
      req = 4'b0010;
      cycle("s6.setup");
      req = 4'b0011;
      for (int b = 0; b < 3; b++) begin
         set_bus(1'b1, 2'd2, 3'd1);
         cycle("s6.nonseq");
         if (b < 2) begin
            check("s6.held", 32'(grant_port), 32'd1);
            HTRANSM = 2'd3;
            cycle("s6.seq");
            cycle("s6.seq");
         end
      end
      check("s6.port0", 32'(grant_port), 32'd0);

      // reset in the middle of a long burst drops the hold
      set_bus(1'b1, 2'd2, 3'd7);
      cycle("s7.nonseq");
      HTRANSM = 2'd3;
      apply_reset();
      req = 4'b0010;
      cycle("s7.after");
      check("s7.grant1", 32'(grant_port), 32'd1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (i % 25 == 0) prio_cfg = 8'($urandom);
         req        = 4'($urandom);
         HREADYM    = ($urandom_range(0, 9) < 8);
         HSELM      = ($urandom_range(0, 9) != 0);
         HTRANSM    = 2'($urandom);
         HBURSTM    = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom);
         HMASTLOCKM = ($urandom_range(0, 19) == 0);
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_qos_arbiter.md
AHB_QOS_ARBITER -- requirements
Module: ahb_qos_arbiter

Interface
REQ-001 SHALL have parameter AGE_LIMIT, default 15, meaning the number of HREADYM-qualified cycles a request waits before it is promoted to the starved class (legal range 1..15).
REQ-002 SHALL have ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  asynchronous active-low reset.
- req  in  4  per-port request, bit n = input port n.
- prio_cfg  in  8  static priority, 2 bits per port (bits [2n+1:2n]); 3 = highest.
- HREADYM  in  1  output-side transfer done.
- HSELM  in  1  slave select of the current owner.
- HTRANSM  in  2  transfer type.
- HBURSTM  in  3  burst type.
- HMASTLOCKM  in  1  locked transfer.
- grant_port  out  2  granted port index.
- no_port  out  1  no port granted.
- starved  out  4  per-port flag: age counter has reached AGE_LIMIT.
REQ-003 SHALL use reset HRESETn, asynchronous, active-low; clock HCLK.

Function
REQ-004 SHALL update grant_port, no_port, the burst state and the age counters only on a rising HCLK edge with HREADYM=1; all state SHALL hold when HREADYM=0.
REQ-005 Burst counter SHALL be cleared when HSELM=0 or HTRANSM=IDLE.
REQ-006 Burst counter SHALL load on NONSEQ with remaining beats 14 (x16), 6 (x8), 2 (x4) or 2 (INCR), with hold=1; SINGLE SHALL load 0 with hold=0.
REQ-007 On SEQ the counter SHALL decrement, dropping hold when it is already 0; BUSY SHALL freeze it.
REQ-008 SHALL count INCR bursts that end early, using a 2-bit counter that increments on a NONSEQ arriving while hold=1 and clears when the next hold=0; a NONSEQ INCR SHALL NOT assert hold when the count is 1.
REQ-009 When HMASTLOCKM=1 or the next hold=1, grant_port and no_port SHALL be held unchanged.
REQ-010 Otherwise, if any starved requester exists, the grant SHALL go to the first starved requester in round-robin order starting at grant_port+1 (mod 4).
REQ-011 Otherwise the grant SHALL go to the requester with the highest prio_cfg value; ties SHALL be broken by round-robin order starting at grant_port+1.
REQ-012 When no_port=1, round-robin order SHALL start at port 0.
REQ-013 With no requests, the current port SHALL be retained if HSELM=1 and no_port=0; otherwise no_port SHALL go to 1 and grant_port SHALL hold its value.
REQ-014 Each of the 4 age counters is 4 bits wide and SHALL behave as follows on an update cycle:
- increment while req[n]=1 and port n is not the granted port;
- saturate at AGE_LIMIT;
- clear when req[n]=0 or when port n is granted for the next cycle.
REQ-015 starved[n] SHALL be combinational: starved[n] = (age[n] == AGE_LIMIT).
REQ-016 The grant decision SHALL use the age values registered before the current edge, giving one cycle of decision latency.
REQ-017 A simultaneous req[n] deassertion and grant to port n SHALL leave the age counter cleared.

Reset
REQ-018 On reset:
- no_port=1, grant_port=0, starved=0;
- burst counter = 0, hold = 0, INCR count = 0;
- all age counters = 0.
REQ-019 Assertion of HRESETn mid-burst or mid-lock SHALL release the hold immediately and asynchronously.

Structure
REQ-020 A shared package SHALL hold:
- the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
- the HBURST encodings;
- the burst-length constants;
- a 2-bit port-index type.
REQ-021 SHALL instantiate one sub-module, ahb_burst_tracker, containing the burst counter, the hold flag and the early-INCR counter, and exporting next_hold.
REQ-022 Priority/round-robin selection SHALL be combinational logic in the top level; no other sub-modules are used.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then req=4'b0100, prio_cfg all 0 -> after 1 edge grant_port=2, no_port=0.
- Port 1 issues INCR4 NONSEQ, then port 3 requests with prio_cfg[7:6]=3 -> grant stays 1 for all 4 beats and moves to 3 on the edge after the last SEQ.
- prio_cfg: port0=3, port2=0; req=4'b0101 continuously, AGE_LIMIT=15:
  - grant goes to 0;
  - starved[2]=1 after 15 update cycles;
  - next decision grants 2 and clears age[2].
- HMASTLOCKM=1 on port 0 with req=4'b1110 -> grant_port stays 0 until HMASTLOCKM=0.
- HREADYM=0 for 5 cycles while requests change -> grant_port, no_port and ages unchanged.
- Three back-to-back 3-beat INCR bursts from port 1 while port 0 requests -> port 0 granted no later than the second early-terminated NONSEQ.
